cpu_bus_arbiter: RTL and testbench

Shares one memory bus between the CPU's instruction-fetch port and data-memory port, so a single-ported memory or bridge can serve both. It sits between the CPU top-level ibus/dbus outputs and the system bus. Exactly one transaction is in flight at a time. Arbitration between the two ports is round-robin or fixed data-priority. A watchdog aborts transactions that are never acknowledged.

---
 rtl/cpu_bus_arbiter_pkg.sv | 30 +++
 rtl/cpu_bus_arbiter_timeout.sv | 42 ++++
 rtl/cpu_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, grant encoding, latched bus request.
package cpu_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Tie goes to data in priority mode, otherwise to the port not granted last.
  function automatic logic pick_winner(input logic ireq, input logic dreq,
                                       input logic data_prio, input logic last);
    if (ireq && dreq) begin
      if (data_prio) return GRANT_D;
      return (last == GRANT_I) ? GRANT_D : GRANT_I;
    end
    return dreq ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_timeout.sv
// Watchdog for the BUS state: expired rises on the (TIMEOUT+1)th consecutive enabled cycle.
module cpu_bus_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             expired_q, expired_d;

  always_comb begin
    cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d     = cnt_inc[CNT_W-1:0];
      expired_d = (TIMEOUT != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT));
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one downstream bus between the CPU fetch and data ports, one transaction at a time.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY = 0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_ibus_request,
  output logic              o_ibus_ready,
  input  logic [ADDR_W-1:0] i_ibus_address,
  output logic [DATA_W-1:0] o_ibus_rdata,
  input  logic              i_dbus_rw,
  input  logic              i_dbus_request,
  output logic              o_dbus_ready,
  input  logic [ADDR_W-1:0] i_dbus_address,
  input  logic [DATA_W-1:0] i_dbus_wdata,
  output logic [DATA_W-1:0] o_dbus_rdata,
  output logic              o_bus_rw,
  output logic              o_bus_request,
  input  logic              i_bus_ready,
  output logic [ADDR_W-1:0] o_bus_address,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic              o_busy,
  output logic              o_fault
);

  localparam logic DATA_PRIO = (PRIORITY != 0);

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  bus_req_t          bus_q, bus_d;
  logic              bus_request_q, bus_request_d;
  logic              ibus_ready_q, ibus_ready_d;
  logic              dbus_ready_q, dbus_ready_d;
  logic [DATA_W-1:0] ibus_rdata_q, ibus_rdata_d;
  logic [DATA_W-1:0] dbus_rdata_q, dbus_rdata_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] resp_c;
  logic              timeout_expired;

  cpu_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .enable  (state_q == ST_BUS),
    .clear   (state_q != ST_BUS),
    .expired (timeout_expired)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    bus_d         = bus_q;
    bus_request_d = bus_request_q;
    ibus_ready_d  = 1'b0;
    dbus_ready_d  = 1'b0;
    ibus_rdata_d  = ibus_rdata_q;
    dbus_rdata_d  = dbus_rdata_q;
    fault_d       = fault_q;
    resp_c        = i_bus_ready ? i_bus_rdata : '0;

    case (state_q)
      ST_IDLE: begin
        if (i_ibus_request || i_dbus_request) begin
          grant_d = pick_winner(i_ibus_request, i_dbus_request, DATA_PRIO, grant_q);
          if (grant_d == GRANT_D) begin
            bus_d.rw    = i_dbus_rw;
            bus_d.addr  = i_dbus_address;
            bus_d.wdata = i_dbus_wdata;
          end else begin
            bus_d.rw    = 1'b0;
            bus_d.addr  = i_ibus_address;
            bus_d.wdata = '0;
          end
          bus_request_d = 1'b1;
          state_d       = ST_BUS;
        end
      end
      ST_BUS: begin
        // A genuine ready wins over a watchdog expiry in the same cycle.
        if (i_bus_ready || timeout_expired) begin
          if (!i_bus_ready) fault_d = 1'b1;
          if (grant_q == GRANT_D) begin
            dbus_rdata_d = resp_c;
            dbus_ready_d = 1'b1;
          end else begin
            ibus_rdata_d = resp_c;
            ibus_ready_d = 1'b1;
          end
          bus_request_d = 1'b0;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= GRANT_I;
      bus_q         <= '0;
      bus_request_q <= 1'b0;
      ibus_ready_q  <= 1'b0;
      dbus_ready_q  <= 1'b0;
      ibus_rdata_q  <= '0;
      dbus_rdata_q  <= '0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      bus_q         <= bus_d;
      bus_request_q <= bus_request_d;
      ibus_ready_q  <= ibus_ready_d;
      dbus_ready_q  <= dbus_ready_d;
      ibus_rdata_q  <= ibus_rdata_d;
      dbus_rdata_q  <= dbus_rdata_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

  assign o_ibus_ready  = ibus_ready_q;
  assign o_ibus_rdata  = ibus_rdata_q;
  assign o_dbus_ready  = dbus_ready_q;
  assign o_dbus_rdata  = dbus_rdata_q;
  assign o_bus_rw      = bus_q.rw;
  assign o_bus_request = bus_request_q;
  assign o_bus_address = bus_q.addr;
  assign o_bus_wdata   = bus_q.wdata;
  assign o_busy        = busy_q;
  assign o_fault       = fault_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench: round-robin and data-priority arbiters on shared stimulus, checked against a transaction-level model.
module tb_cpu_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, drw = 1'b0, bready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, brdata = '0;

  logic        r_irdy, r_drdy, r_rw, r_breq, r_busy, r_fault;
  logic [31:0] r_irdata, r_drdata, r_addr, r_wdata;
  logic        p_irdy, p_drdy, p_rw, p_breq, p_busy, p_fault;
  logic [31:0] p_irdata, p_drdata, p_addr, p_wdata;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.PRIORITY(0), .TIMEOUT(TO)) dut_rr (
    .i_clock(clk), .i_reset(rst),
    .i_ibus_request(ireq), .o_ibus_ready(r_irdy), .i_ibus_address(iaddr), .o_ibus_rdata(r_irdata),
    .i_dbus_rw(drw), .i_dbus_request(dreq), .o_dbus_ready(r_drdy), .i_dbus_address(daddr),
    .i_dbus_wdata(dwdata), .o_dbus_rdata(r_drdata),
    .o_bus_rw(r_rw), .o_bus_request(r_breq), .i_bus_ready(bready), .o_bus_address(r_addr),
    .i_bus_rdata(brdata), .o_bus_wdata(r_wdata), .o_busy(r_busy), .o_fault(r_fault)
  );

  cpu_bus_arbiter #(.PRIORITY(1), .TIMEOUT(TO)) dut_pr (
    .i_clock(clk), .i_reset(rst),
    .i_ibus_request(ireq), .o_ibus_ready(p_irdy), .i_ibus_address(iaddr), .o_ibus_rdata(p_irdata),
    .i_dbus_rw(drw), .i_dbus_request(dreq), .o_dbus_ready(p_drdy), .i_dbus_address(daddr),
    .i_dbus_wdata(dwdata), .o_dbus_rdata(p_drdata),
    .o_bus_rw(p_rw), .o_bus_request(p_breq), .i_bus_ready(bready), .o_bus_address(p_addr),
    .i_bus_rdata(brdata), .o_bus_wdata(p_wdata), .o_busy(p_busy), .o_fault(p_fault)
  );

  int          checks = 0;
  int          errors = 0;
  bit          last_g;      // model: last granted port, 1 = data
  bit          fault_exp;
  logic [31:0] irdata_exp, drdata_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_g     = 1'b0;
    fault_exp  = 1'b0;
    irdata_exp = '0;
    drdata_exp = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r_ctl"}, {26'd0, r_irdy, r_drdy, r_rw, r_breq, r_busy, r_fault}, 32'd0);
    chk({tag, "_r_irdata"}, r_irdata, 32'd0);
    chk({tag, "_r_drdata"}, r_drdata, 32'd0);
    chk({tag, "_r_addr"}, r_addr, 32'd0);
    chk({tag, "_r_wdata"}, r_wdata, 32'd0);
    chk({tag, "_p_ctl"}, {26'd0, p_irdy, p_drdy, p_rw, p_breq, p_busy, p_fault}, 32'd0);
  endtask

  // One arbitrated transaction; request is sampled at the next edge (cycle 0 -> cycle 1).
  // wait_n: cycles of downstream wait; hang: never acknowledge; keep: leave requests high afterwards.
  task automatic txn(input bit ir, input bit dr, input int wait_n, input bit hang,
                     input bit keep, input logic [31:0] resp);
    bit          w, pw;
    logic [31:0] ea, ewd, erd;
    bit          erw;
    int          extra;
    w   = (ir && dr) ? ~last_g : dr;
    pw  = dr;
    ea  = w ? daddr : iaddr;
    erw = w ? drw : 1'b0;
    ewd = w ? dwdata : 32'd0;
    ireq = ir;
    dreq = dr;
    step();
    last_g = w;
    chk("grant_breq", {31'd0, r_breq}, 32'd1);
    chk("grant_busy", {31'd0, r_busy}, 32'd1);
    chk("grant_addr", r_addr, ea);
    chk("grant_rw", {31'd0, r_rw}, {31'd0, erw});
    chk("grant_wdata", r_wdata, ewd);
    chk("pr_grant_addr", p_addr, pw ? daddr : iaddr);
    extra = hang ? TO : wait_n;
    for (int k = 0; k < extra; k++) begin
      brdata = $urandom;
      step();
      chk("wait_readys", {30'd0, r_irdy, r_drdy}, 32'd0);
      chk("wait_breq", {31'd0, r_breq}, 32'd1);
      chk("wait_addr", r_addr, ea);
    end
    if (!hang) begin
      bready = 1'b1;
      brdata = resp;
    end
    step();
    bready = 1'b0;
    erd = hang ? 32'd0 : resp;
    if (hang) fault_exp = 1'b1;
    if (w) drdata_exp = erd; else irdata_exp = erd;
    chk("done_irdy", {31'd0, r_irdy}, {31'd0, ~w});
    chk("done_drdy", {31'd0, r_drdy}, {31'd0, w});
    chk("done_irdata", r_irdata, irdata_exp);
    chk("done_drdata", r_drdata, drdata_exp);
    chk("done_breq", {31'd0, r_breq}, 32'd0);
    chk("done_fault", {31'd0, r_fault}, {31'd0, fault_exp});
    chk("pr_done_rdy", {31'd0, pw ? p_drdy : p_irdy}, 32'd1);
    chk("pr_done_fault", {31'd0, p_fault}, {31'd0, fault_exp});
    step();
    chk("idle_readys", {28'd0, r_irdy, r_drdy, p_irdy, p_drdy}, 32'd0);
    chk("idle_breq", {31'd0, r_breq}, 32'd0);
    chk("idle_busy", {31'd0, r_busy}, 32'd0);
    if (!keep) begin
      if (w) dreq = 1'b0; else ireq = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("post_reset");

    // Fetch only, zero-wait downstream.
    iaddr = 32'h100;
    txn(1'b1, 1'b0, 0, 1'b0, 1'b0, 32'hDEADBEEF);

    // Data write with two wait states.
    daddr = 32'h2000; dwdata = 32'h12345678; drw = 1'b1;
    txn(1'b0, 1'b1, 2, 1'b0, 1'b0, 32'h0BADF00D);

    // Fetch with 5 wait states, request held through DONE.
    iaddr = 32'h340;
    txn(1'b1, 1'b0, 5, 1'b0, 1'b0, 32'hCAFEF00D);
    step();
    chk("held_no_regrant", {31'd0, r_breq}, 32'd0);

    // Watchdog abort, then a normal transaction with sticky fault.
    daddr = 32'h4000; drw = 1'b0;
    txn(1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h0);
    iaddr = 32'h104;
    txn(1'b1, 1'b0, 1, 1'b0, 1'b0, 32'h55AA55AA);

    // Reset while in BUS: immediate clear, no ready pulse.
    iaddr = 32'h108;
    ireq = 1'b1;
    step();
    step();
    chk("pre_rst_breq", {31'd0, r_breq}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    ireq = 1'b0;
    step();
    chk_all_zero("mid_rst_hold");
    rst = 1'b0;
    model_reset();
    step();
    chk_all_zero("after_rst");

    // Both ports held: round-robin D,I,D,I; priority instance grants D each time.
    iaddr = 32'h200; daddr = 32'h3000; dwdata = 32'hA5A5A5A5; drw = 1'b1;
    for (int t = 0; t < 4; t++) begin
      txn(1'b1, 1'b1, t % 2, 1'b0, 1'b1, 32'h1000 + 32'(t));
      chk("rr_order", {31'd0, last_g}, {31'd0, (t % 2) == 0});
    end
    ireq = 1'b0;
    dreq = 1'b0;
    step();

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      bit ir, dr;
      ir     = 1'($urandom_range(0, 1));
      dr     = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      iaddr  = $urandom;
      daddr  = $urandom;
      dwdata = $urandom;
      drw    = 1'($urandom_range(0, 1));
      txn(ir, dr, $urandom_range(0, 6), ($urandom_range(0, 7) == 0), 1'b0, $urandom);
      ireq = 1'b0;
      dreq = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
